// File: rtl/jtag_scan_hub.sv
// jtag_scan_hub: BSR (data+oe per cell), debug and MBIST-bypass JTAG data registers on TAP strobes.
// Latency: capture/shift visible on tdo one tck after the strobe edge; update latches visible the next cycle.
// Backpressure: none; the TAP strobes fully pace the registers. Optional macro: JTAG_HUB_DBG_PARITY_EN.
module jtag_scan_hub #(
  parameter int BSR_LEN   = 15,
  parameter int DBG_IN_W  = 16,
  parameter int DBG_OUT_W = 8
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 test_logic_reset_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 pause_dr_i,
  input  logic                 update_dr_i,
  input  logic                 extest_select_i,
  input  logic                 sample_preload_select_i,
  input  logic                 debug_select_i,
  input  logic                 mbist_select_i,
  input  logic                 tdi_i,
  output logic                 bs_tdo_o,
  output logic                 dbg_tdo_o,
  output logic                 mbist_tdo_o,
  input  logic [BSR_LEN-1:0]   bsr_i,
  output logic [BSR_LEN-1:0]   bsr_o,
  output logic [BSR_LEN-1:0]   bsr_oe,
  input  logic [DBG_IN_W-1:0]  dbg_i,
  output logic [DBG_OUT_W-1:0] dbg_o,
  output logic                 upd_err_o
);

  localparam int BSR_SR_W = 2 * BSR_LEN;
`ifdef JTAG_HUB_DBG_PARITY_EN
  localparam int DBG_SR_W = DBG_IN_W + 1;
`else
  localparam int DBG_SR_W = DBG_IN_W;
`endif

  logic                 bsr_sel;
  logic                 any_sel;
  logic                 cap;
  logic                 shf;
  logic                 upd;
  logic                 dbg_par_ok;
  logic [BSR_SR_W-1:0]  bsr_sr;
  logic [BSR_SR_W-1:0]  bsr_cap;
  logic [BSR_LEN-1:0]   upd_dat;
  logic [BSR_LEN-1:0]   upd_oe;
  logic [DBG_SR_W-1:0]  dbg_sr;
  logic [DBG_SR_W-1:0]  dbg_cap;
  logic                 mbist_sr;

  // Strobe priority: capture beats shift beats update; pause freezes everything.
  assign bsr_sel = extest_select_i | sample_preload_select_i;
  assign any_sel = bsr_sel | debug_select_i | mbist_select_i;
  assign cap     = capture_dr_i;
  assign shf     = shift_dr_i  & ~capture_dr_i & ~pause_dr_i;
  assign upd     = update_dr_i & ~capture_dr_i & ~shift_dr_i & ~pause_dr_i;

`ifdef JTAG_HUB_DBG_PARITY_EN
  // Parity bit makes the captured register even over all its bits.
  assign dbg_cap    = {^dbg_i, dbg_i};
  assign dbg_par_ok = ~(^dbg_sr);
`else
  assign dbg_cap    = dbg_i;
  assign dbg_par_ok = 1'b1;
`endif

  // Interleave cells into the BSR chain: even bit = data, odd bit = output enable.
  always_comb begin
    bsr_cap = '0;
    upd_dat = '0;
    upd_oe  = '0;
    for (int k = 0; k < BSR_LEN; k++) begin
      bsr_cap[2*k]   = bsr_i[k];
      bsr_cap[2*k+1] = bsr_oe[k];
      upd_dat[k]     = bsr_sr[2*k];
      upd_oe[k]      = bsr_sr[2*k+1];
    end
  end

  // BSR shift register and its data/oe update latches.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      bsr_sr <= '0;
      bsr_o  <= '0;
      bsr_oe <= '0;
    end else if (test_logic_reset_i) begin
      bsr_sr <= '0;
      bsr_o  <= '0;
      bsr_oe <= '0;
    end else if (bsr_sel) begin
      if (cap) begin
        bsr_sr <= bsr_cap;
      end else if (shf) begin
        bsr_sr <= {tdi_i, bsr_sr[BSR_SR_W-1:1]};
      end else if (upd) begin
        bsr_o  <= upd_dat;
        bsr_oe <= upd_oe;
      end
    end
  end

  // Debug shift register; update gated by parity when that build option is on.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      dbg_sr <= '0;
      dbg_o  <= '0;
    end else if (test_logic_reset_i) begin
      dbg_sr <= '0;
      dbg_o  <= '0;
    end else if (debug_select_i) begin
      if (cap) begin
        dbg_sr <= dbg_cap;
      end else if (shf) begin
        dbg_sr <= {tdi_i, dbg_sr[DBG_SR_W-1:1]};
      end else if (upd && dbg_par_ok) begin
        dbg_o  <= dbg_sr[DBG_OUT_W-1:0];
      end
    end
  end

  // One-bit MBIST bypass: captures 0, shifts tdi, never updates.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      mbist_sr <= 1'b0;
    end else if (test_logic_reset_i) begin
      mbist_sr <= 1'b0;
    end else if (mbist_select_i) begin
      if (cap) begin
        mbist_sr <= 1'b0;
      end else if (shf) begin
        mbist_sr <= tdi_i;
      end
    end
  end

  // Sticky error: orphan update, or a debug update rejected by parity.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      upd_err_o <= 1'b0;
    end else if (test_logic_reset_i) begin
      upd_err_o <= 1'b0;
    end else if (upd && (!any_sel || (debug_select_i && !dbg_par_ok))) begin
      upd_err_o <= 1'b1;
    end
  end

  assign bs_tdo_o    = bsr_sr[0];
  assign dbg_tdo_o   = dbg_sr[0];
  assign mbist_tdo_o = mbist_sr;

endmodule

// File: tb/tb_jtag_scan_hub.sv
// Testbench for jtag_scan_hub: directed test-plan scenarios plus randomized TAP sequences.
// Expected outputs come from a queue-based model and are compared by a monitor every tck.
module tb_jtag_scan_hub;
  localparam int BL = 15;
  localparam int DI = 16;
  localparam int DO = 8;
`ifdef JTAG_HUB_DBG_PARITY_EN
  localparam int DW = DI + 1;
`else
  localparam int DW = DI;
`endif

  typedef struct packed {
    logic          bs;
    logic          dbg;
    logic          mb;
    logic [BL-1:0] bo;
    logic [BL-1:0] boe;
    logic [DO-1:0] dbo;
    logic          err;
  } obs_t;

  logic tck = 1'b0;
  logic trst_ni = 1'b0;
  logic tlr = 1'b0, cap = 1'b0, shf = 1'b0, pau = 1'b0, upd = 1'b0;
  logic ext = 1'b0, spl = 1'b0, dsel = 1'b0, msel = 1'b0, tdi = 1'b0;
  logic bs_tdo, dbg_tdo, mb_tdo, upd_err;
  logic [BL-1:0] bsr_i = '0, bsr_o, bsr_oe;
  logic [DI-1:0] dbg_i = '0;
  logic [DO-1:0] dbg_o;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t exp_q[$];

  // reference model state: queues hold chain bits, element 0 is the bit on tdo
  bit q_bsr[$];
  bit q_dbg[$];
  bit m_mb;
  logic [BL-1:0] m_bo, m_boe;
  logic [DO-1:0] m_dbo;
  bit m_err;

  always #5 tck = ~tck;

  jtag_scan_hub #(.BSR_LEN(BL), .DBG_IN_W(DI), .DBG_OUT_W(DO)) dut (
    .tck_i(tck), .trst_ni(trst_ni), .test_logic_reset_i(tlr),
    .capture_dr_i(cap), .shift_dr_i(shf), .pause_dr_i(pau), .update_dr_i(upd),
    .extest_select_i(ext), .sample_preload_select_i(spl),
    .debug_select_i(dsel), .mbist_select_i(msel), .tdi_i(tdi),
    .bs_tdo_o(bs_tdo), .dbg_tdo_o(dbg_tdo), .mbist_tdo_o(mb_tdo),
    .bsr_i(bsr_i), .bsr_o(bsr_o), .bsr_oe(bsr_oe),
    .dbg_i(dbg_i), .dbg_o(dbg_o), .upd_err_o(upd_err)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    q_bsr.delete();
    q_dbg.delete();
    for (int i = 0; i < 2*BL; i++) q_bsr.push_back(1'b0);
    for (int i = 0; i < DW; i++) q_dbg.push_back(1'b0);
    m_mb = 1'b0; m_bo = '0; m_boe = '0; m_dbo = '0; m_err = 1'b0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bs = q_bsr[0]; o.dbg = q_dbg[0]; o.mb = m_mb;
    o.bo = m_bo; o.boe = m_boe; o.dbo = m_dbo; o.err = m_err;
    return o;
  endfunction

  // one TAP cycle of the model, written as chain operations on bit queues
  task automatic model_step();
    bit bsel;
    int ones;
    bsel = ext | spl;
    if (tlr) begin
      model_reset();
    end else if (cap) begin
      if (bsel) begin
        q_bsr.delete();
        for (int k = 0; k < BL; k++) begin
          q_bsr.push_back(bsr_i[k]);
          q_bsr.push_back(m_boe[k]);
        end
      end
      if (dsel) begin
        q_dbg.delete();
        for (int i = 0; i < DI; i++) q_dbg.push_back(dbg_i[i]);
`ifdef JTAG_HUB_DBG_PARITY_EN
        q_dbg.push_back(^dbg_i);
`endif
      end
      if (msel) m_mb = 1'b0;
    end else if (shf) begin
      if (bsel) begin void'(q_bsr.pop_front()); q_bsr.push_back(tdi); end
      if (dsel) begin void'(q_dbg.pop_front()); q_dbg.push_back(tdi); end
      if (msel) m_mb = tdi;
    end else if (pau) begin
      // hold
    end else if (upd) begin
      if (bsel) begin
        for (int k = 0; k < BL; k++) begin
          m_bo[k]  = q_bsr[2*k];
          m_boe[k] = q_bsr[2*k+1];
        end
      end else if (dsel) begin
        ones = 0;
        foreach (q_dbg[i]) ones += int'(q_dbg[i]);
`ifdef JTAG_HUB_DBG_PARITY_EN
        if (ones % 2 != 0) m_err = 1'b1;
        else for (int i = 0; i < DO; i++) m_dbo[i] = q_dbg[i];
`else
        for (int i = 0; i < DO; i++) m_dbo[i] = q_dbg[i];
`endif
      end else if (!msel) begin
        m_err = 1'b1;
      end
    end
  endtask

  // called at a negedge: drive, predict, then advance one full cycle
  task automatic tick(input logic c, input logic s, input logic p, input logic u,
                      input logic t, input logic d);
    trst_ni = 1'b1;
    cap = c; shf = s; pau = p; upd = u; tlr = t; tdi = d;
    model_step();
    exp_q.push_back(model_obs());
    @(posedge tck);
    @(negedge tck);
  endtask

  task automatic set_sel(input int s);
    ext = (s == 0); spl = (s == 1); dsel = (s == 2); msel = (s == 3);
  endtask

  task automatic idle();              tick(0, 0, 0, 0, 0, 0); endtask
  task automatic do_cap();            tick(1, 0, 0, 0, 0, 0); endtask
  task automatic do_shf(input logic b); tick(0, 1, 0, 0, 0, b); endtask
  task automatic do_pau();            tick(0, 0, 1, 0, 0, 0); endtask
  task automatic do_upd();            tick(0, 0, 0, 1, 0, 0); endtask
  task automatic do_tlr();            tick(0, 0, 0, 0, 1, 0); endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_bsr_o"}, bsr_o, 0);
    chk({nm, "_bsr_oe"}, bsr_oe, 0);
    chk({nm, "_dbg_o"}, dbg_o, 0);
    chk({nm, "_err"}, upd_err, 0);
    chk({nm, "_tdo"}, {bs_tdo, dbg_tdo, mb_tdo}, 0);
  endtask

  // monitor: pop the prediction for the edge just taken and compare
  initial begin
    obs_t e, g;
    forever begin
      @(posedge tck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{bs: bs_tdo, dbg: dbg_tdo, mb: mb_tdo, bo: bsr_o, boe: bsr_oe, dbo: dbg_o, err: upd_err};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL cycle_obs t=%0t got=%h exp=%h", $time, g, e);
        end
      end
    end
  end

  initial begin
    logic [2*BL-1:0] d30;
    logic [BL-1:0]   e_bo, e_boe;
    logic [DW-1:0]   dd;
    logic [DI-1:0]   stream;
    int              n;

    // reset state
    @(negedge tck); @(negedge tck);
    chk_all_zero("reset");
    model_reset();

    // EXTEST: interleaved capture streams out, then update drives all oe high
    set_sel(0);
    bsr_i = 15'h5A5A;
    do_cap();
    d30 = 30'h2AAAAAAA;
    for (int i = 0; i < 2*BL; i++) do_shf(d30[i]);
    do_upd();
    chk("extest_bsr_o", bsr_o, 15'h0000);
    chk("extest_bsr_oe", bsr_oe, 15'h7FFF);

    // reset mid-shift, asserted asynchronously between edges
    do_cap();
    for (int i = 0; i < 5; i++) do_shf(1'b1);
    #2 trst_ni = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    exp_q.push_back(model_obs());
    @(posedge tck); @(negedge tck);

    // SAMPLE/PRELOAD with and without a pause must give identical latches
    set_sel(1);
    d30 = 30'h1234_5678;
    for (int k = 0; k < BL; k++) begin e_bo[k] = d30[2*k]; e_boe[k] = d30[2*k+1]; end
    for (int run = 0; run < 2; run++) begin
      bsr_i = 15'(run * 15'h1111 + 15'h0F0F);
      do_cap();
      for (int i = 0; i < 2*BL; i++) begin
        if (run == 0 && i == 10) repeat (4) do_pau();
        do_shf(d30[i]);
      end
      do_upd();
      chk($sformatf("preload_bsr_o_%0d", run), bsr_o, e_bo);
      chk($sformatf("preload_bsr_oe_%0d", run), bsr_oe, e_boe);
    end

    // debug register: capture stream and update
    set_sel(2);
    dbg_i = 16'hBEEF;
    do_cap();
    dd = '0;
    dd[DI-1:0] = 16'h00C3;
`ifdef JTAG_HUB_DBG_PARITY_EN
    dd[DW-1] = ^dd[DI-1:0];
`endif
    for (int i = 0; i < DW; i++) begin
      if (i < DI) stream[i] = dbg_tdo;
      do_shf(dd[i]);
    end
    chk("dbg_stream", stream, 16'hBEEF);
    do_upd();
    chk("dbg_o", dbg_o, 8'hC3);
    chk("dbg_err", upd_err, 0);

`ifdef JTAG_HUB_DBG_PARITY_EN
    // bad parity: latch holds, sticky error sets, test-logic-reset clears it
    do_cap();
    dd = '0;
    dd[DI-1:0] = 16'h0055;
    dd[DW-1] = ~(^dd[DI-1:0]);
    for (int i = 0; i < DW; i++) do_shf(dd[i]);
    do_upd();
    chk("par_dbg_hold", dbg_o, 8'hC3);
    chk("par_err_set", upd_err, 1);
    do_tlr();
    chk("par_err_clr", upd_err, 0);
`endif

    // orphan update
    e_bo = m_bo;
    set_sel(4);
    do_upd();
    chk("orphan_err", upd_err, 1);
    chk("orphan_bsr_o", bsr_o, e_bo);
    chk("orphan_dbg_o", dbg_o, m_dbo);
    do_tlr();
    chk("tlr_err_clr", upd_err, 0);

    // randomized TAP sequences
    for (int it = 0; it < 300; it++) begin
      set_sel($urandom_range(0, 4));
      bsr_i = BL'($urandom);
      dbg_i = DI'($urandom);
      if ($urandom_range(0, 9) == 0) do_tlr();
      do_cap();
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) do_pau();
        do_shf(1'($urandom));
      end
      if ($urandom_range(0, 3) != 0) begin
        do_upd();
        if ($urandom_range(0, 4) == 0) do_upd();
      end
      idle();
    end

    idle();
    idle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtag_scan_hub.md
# jtag_scan_hub

- Parametrised JTAG data-register hub; replaces the fixed 15-cell boundary-scan / 16-in 8-out debug test interface between the TAP controller and the voltmeter core.
- Holds three data registers selected by the instruction decode from the TAP: boundary-scan (BSR), debug, and a 1-bit MBIST bypass.
- Each register runs capture/shift/update on the TAP strobes, with widths set by parameters.
- New in this generation: per-cell output-enable scan bits, a sticky update-error flag, and optional parity-protected debug updates.

## Interface
Parameters:
- BSR_LEN, 15, number of boundary cells; scan length is 2*BSR_LEN (data + oe per cell)
- DBG_IN_W, 16, debug capture width (digital status into scan)
- DBG_OUT_W, 8, debug update width (analog test controls); must be ≤ DBG_IN_W

Ports:
- tck_i  in  1  sole clock, all state on rising edge
- trst_ni  in  1  asynchronous active-low reset
- test_logic_reset_i  in  1  TAP in Test-Logic-Reset; synchronous clear
- capture_dr_i / shift_dr_i / pause_dr_i / update_dr_i  in  1 each  TAP state strobes, one-hot
- extest_select_i / sample_preload_select_i / debug_select_i / mbist_select_i  in  1 each  decoded instruction, at most one high
- tdi_i  in  1  serial in from TAP
- bs_tdo_o / dbg_tdo_o / mbist_tdo_o  out  1 each  serial out of each register (its bit 0)
- bsr_i  in  BSR_LEN  pad-side values captured by BSR
- bsr_o  out  BSR_LEN  BSR data update latch
- bsr_oe  out  BSR_LEN  BSR output-enable update latch (1 = drive)
- dbg_i  in  DBG_IN_W  digital debug status
- dbg_o  out  DBG_OUT_W  debug update latch to analog test mux
- upd_err_o  out  1  sticky: update_dr seen with no DR-type instruction selected

## Operation
- BSR shift register, 2*BSR_LEN bits. Bit 2k = data of cell k, bit 2k+1 = oe of cell k. Shifts toward bit 0; tdi_i enters at MSB.
- BSR capture (capture_dr_i & (extest|sample_preload)): data bits ← bsr_i[k]; oe bits ← bsr_oe[k].
- BSR shift (shift_dr_i & same selects): sr ← {tdi_i, sr[MSB:1]}.
- BSR update (update_dr_i & same selects): bsr_o[k] ← sr[2k], bsr_oe[k] ← sr[2k+1].
- Debug register: DBG_IN_W bits, plus parity bit when enabled.
  - Capture (debug_select_i): sr ← dbg_i.
  - Shift: as BSR.
  - Update: dbg_o ← sr[DBG_OUT_W-1:0].
- MBIST bypass: 1 bit. Captures 0. Shifts tdi_i when mbist_select_i. No update.
- pause_dr_i, or no strobe active: all registers hold.
- Unselected registers hold; their tdo outputs stay stable.
- Priority within a cycle: trst_ni > test_logic_reset_i > capture > shift > update.
- upd_err_o: set when update_dr_i arrives with no select high. Cleared only by reset or test_logic_reset_i.

## Timing
- Reset (async trst_ni low, or sync test_logic_reset_i) clears every output to 0: bsr_o, bsr_oe (all cells high-Z), dbg_o, upd_err_o, and all tdo outputs.
- Shift registers also clear.
- Capture: register loads at the rising tck edge where capture_dr_i is high. The tdo output shows the captured bit 0 immediately after that edge.
- Shift: one bit per tck edge while shift_dr_i is high.
  - A full BSR unload takes 2*BSR_LEN edges.
  - The first bit presented (captured data of cell 0) is present before the first shift edge.
- Update: latches load at the rising edge where update_dr_i is high. They are visible the next cycle and held until the next update or reset.
- update_dr_i is one cycle wide. If held high for multiple cycles, the latches reload the same value each cycle (idempotent).
- tdo outputs are registered bit 0 values; no combinational path from tdi_i.

## Configuration
- JTAG_HUB_DBG_PARITY_EN defined:
  - Debug register is DBG_IN_W+1 bits; MSB is the parity bit.
  - Capture loads ^dbg_i into the MSB, giving even parity over the whole register.
  - On update, dbg_o loads only if XOR over all DBG_IN_W+1 bits is 0. Otherwise dbg_o holds and upd_err_o sets.
- Not defined: DBG_IN_W-bit register, updates unconditional, upd_err_o set only by the no-select case.

## Test plan
- Reset mid-shift: pulse trst_ni low after 5 BSR shifts -> all outputs 0 asynchronously; bsr_oe = 0.
- EXTEST defaults: capture with bsr_i=15'h5A5A, shift 30 bits of 30'h2AAAAAAA -> bs_tdo_o stream reproduces the interleaved capture (oe bits 0); after update, bsr_o=15'h0000, bsr_oe=15'h7FFF.
- SAMPLE/PRELOAD with pause: pause_dr mid-shift for 4 cycles -> sr unchanged; completion yields the same bsr_o as an unpaused run.
- Debug update: dbg_i=16'hBEEF, shift in 16'h00C3 -> dbg_tdo_o stream = 16'hBEEF LSB first; dbg_o=8'hC3.
- Parity (macro on): shift 17 bits with bad parity -> dbg_o holds previous value, upd_err_o=1; test_logic_reset_i clears it to 0.
- Orphan update: update_dr_i with no select -> upd_err_o=1; bsr_o, dbg_o unchanged.
